// File: rtl/fifo_pkg.sv
// Shared types and constants for the async-FIFO read-side stream adapter.
// The optional delivered-word counter is enabled by FIFO_RD_CNT_EN.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUF_DEPTH      = 2;

    typedef logic [1:0]  occ_t;
    typedef logic [15:0] cnt_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry FIFO-ordered output buffer feeding the stream interface.
// Unaffected by FIFO_RD_CNT_EN.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output occ_t          occ,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [BUF_DEPTH];
    logic [DW-1:0] mem_d [BUF_DEPTH];
    logic          head_q, head_d;
    logic          tail_q, tail_d;
    occ_t          occ_q, occ_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q ^ pop;
        tail_d = tail_q ^ push;
        occ_d  = occ_q + occ_t'(push) - occ_t'(pop);
        if (push) begin
            mem_d[tail_q] = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign dout = mem_q[head_q];

    // The upstream credit rule must never let a word land in a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occ_q == occ_t'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read port (1-cycle latency) to valid/ready stream converter.
// Define FIFO_RD_CNT_EN to add the 16-bit word_cnt delivered-word counter.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output cnt_t                  word_cnt
`endif
);

    logic       inflight_q, inflight_d;
    logic       push, pop;
    logic [2:0] committed;
    occ_t       occ;

    assign pop  = m_valid & m_ready;
    assign push = inflight_q;

    // Entries held plus the word in flight, minus the one leaving now.
    always_comb begin
        committed  = 3'(occ) + 3'(inflight_q) - 3'(pop);
        fifo_rd_en = !rrst && !fifo_empty && (committed < 3'(BUF_DEPTH));
        inflight_d = fifo_rd_en;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_skid_buf #(
        .DW (DATA_WIDTH)
    ) u_buf (
        .clk  (rclk),
        .rst  (rrst),
        .push (push),
        .pop  (pop),
        .din  (fifo_data),
        .occ  (occ),
        .dout (m_data)
    );

    assign m_valid = (occ != '0);

`ifdef FIFO_RD_CNT_EN
    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + cnt_t'(pop);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed self-checking bench for fifo_rd_stream_adapter.
// The word counter checks run only when FIFO_RD_CNT_EN is defined.
module tb_fifo_rd_stream_adapter;
    import fifo_pkg::*;

    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
    cnt_t          word_cnt;
    cnt_t          exp_cnt = '0;
`endif

    int            n_assert = 0;
    int            n_fail = 0;
    int            n_rd = 0;
    bit            force_empty = 1'b0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] outq[$];
    logic [DW-1:0] refq[$];

    always #5 rclk = ~rclk;

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (DW)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prep();
        fifo_empty = force_empty || (fq.size() == 0);
        #2;
    endtask

    task automatic edge_step();
        logic          rd, v, rdy;
        logic [DW-1:0] d;
        rd  = fifo_rd_en;
        v   = m_valid;
        rdy = m_ready;
        d   = m_data;
        chk("rd_while_empty", 32'(rd & fifo_empty), 32'd0);
        if (rd) n_rd++;
        if (v && rdy) begin
            outq.push_back(d);
`ifdef FIFO_RD_CNT_EN
            exp_cnt++;
`endif
        end
        @(posedge rclk);
        #1;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
        else fifo_data = DW'($urandom);
        if (v && !rdy) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(d));
        end
`ifdef FIFO_RD_CNT_EN
        chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
`endif
    endtask

    task automatic step();
        prep();
        edge_step();
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        fq.delete();
        outq.delete();
        force_empty = 1'b0;
        fifo_empty = 1'b1;
        @(posedge rclk);
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_RD_CNT_EN
        exp_cnt = '0;
        chk("rst_cnt", 32'(word_cnt), 32'd0);
`endif
        @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] t1 [3];
        int            cyc;
        t1 = '{8'h11, 8'h22, 8'h33};

        // Test 1: three preloaded words, sink always ready
        do_reset();
        fq = '{8'h11, 8'h22, 8'h33};
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prep();
            chk($sformatf("t1_rd_c%0d", i), 32'(fifo_rd_en), 32'(i < 3));
            chk($sformatf("t1_v_c%0d", i), 32'(m_valid),
                32'(i >= 2 && i <= 4));
            if (i >= 2 && i <= 4)
                chk($sformatf("t1_d_c%0d", i), 32'(m_data), 32'(t1[i-2]));
            edge_step();
        end

        // Test 2: back-pressure with five words, then drain
        do_reset();
        fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        m_ready = 1'b0;
        n_rd = 0;
        repeat (6) step();
        chk("t2_reads", 32'(n_rd), 32'd2);
        prep();
        chk("t2_rd_off", 32'(fifo_rd_en), 32'd0);
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_head", 32'(m_data), 32'hA1);
        m_ready = 1'b1;
        repeat (5) step();
        chk("t2_count", 32'(outq.size()), 32'd5);
        for (int i = 0; i < 5 && i < outq.size(); i++)
            chk($sformatf("t2_word%0d", i), 32'(outq[i]), 32'(8'hA1 + i));
        prep();
        chk("t2_drained", 32'(m_valid), 32'd0);

        // Test 3: FIFO empty throughout, sink toggling
        do_reset();
        force_empty = 1'b1;
        n_rd = 0;
        for (int i = 0; i < 16; i++) begin
            m_ready = i[0];
            prep();
            chk("t3_valid", 32'(m_valid), 32'd0);
            edge_step();
        end
        chk("t3_reads", 32'(n_rd), 32'd0);
        force_empty = 1'b0;

        // Test 5: async reset with a buffered word and one in flight
        do_reset();
        fq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        m_ready = 1'b0;
        step();
        step();
        prep();
        chk("t5_pre_valid", 32'(m_valid), 32'd1);
        chk("t5_pre_rd", 32'(fifo_rd_en), 32'd0);
        rrst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(m_valid), 32'd0);
        chk("t5_async_data", 32'(m_data), 32'd0);
        chk("t5_async_rd", 32'(fifo_rd_en), 32'd0);
        do_reset();
        fq = '{8'hC1, 8'hC2};
        m_ready = 1'b1;
        repeat (6) step();
        chk("t5_count", 32'(outq.size()), 32'd2);
        if (outq.size() == 2) begin
            chk("t5_word0", 32'(outq[0]), 32'hC1);
            chk("t5_word1", 32'(outq[1]), 32'hC2);
        end

        // Test 4: random sink and empty flag over 1000 words
        do_reset();
        refq.delete();
        for (int i = 0; i < 1000; i++) begin
            refq.push_back(DW'($urandom));
        end
        fq = refq;
        cyc = 0;
        while (outq.size() < 1000 && cyc < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 3) == 0);
            step();
            cyc++;
        end
        force_empty = 1'b0;
        chk("t4_count", 32'(outq.size()), 32'd1000);
        for (int i = 0; i < 1000 && i < outq.size(); i++)
            chk("t4_order", 32'(outq[i]), 32'(refq[i]));

`ifdef FIFO_RD_CNT_EN
        // Test 6: pump the counter up to 0xFFFE, then watch it wrap
        do_reset();
        for (int i = 0; i < 65534; i++) fq.push_back(DW'(i));
        m_ready = 1'b1;
        cyc = 0;
        while (outq.size() < 65534 && cyc < 70000) begin
            step();
            cyc++;
        end
        chk("t6_preload", 32'(word_cnt), 32'hFFFE);
        fq = '{8'hD1, 8'hD2, 8'hD3};
        cyc = 0;
        while (outq.size() < 65537 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t6_wrapped", 32'(word_cnt), 32'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
